sqrt_iter: RTL and testbench

- Parametrised, multi-cycle, unsigned fixed-point square-root unit for the ALU.
- Successor to the single-width sqrt: generic data width, optional extra result fraction bits, start/busy/done handshake, held outputs.
- Non-restoring digit-by-digit algorithm; one result bit per clock; one operation in flight.

---
 rtl/sqrt_iter.sv | 123 ++++++++++++
 tb/tb_sqrt_iter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - multi-cycle non-restoring unsigned fixed-point square root, one root bit per clock.
// Optional macro SQRT_ITER_ROUND_EN: extra guard iteration, round-half-up result saturating at all-ones.
module sqrt_iter #(
  parameter int DATA_W   = 32,
  parameter int EXT_FRAC = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [DATA_W-1:0]              in,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_W/2+EXT_FRAC-1:0]   out,
  output logic [DATA_W/2+EXT_FRAC:0]     rout
);

  localparam int ROOT_W = DATA_W/2 + EXT_FRAC;
  localparam int REM_W  = ROOT_W + 1;
`ifdef SQRT_ITER_ROUND_EN
  localparam int NIT    = ROOT_W + 1;
`else
  localparam int NIT    = ROOT_W;
`endif
  localparam int RM_W   = NIT + 2;
  localparam int RAD_W  = 2 * NIT;
  localparam int CNT_W  = $clog2(NIT);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t            r_state, w_state_nx;
  logic              w_accept, w_last;
  logic [RAD_W-1:0]  r_rad, w_in_ext;
  logic [RM_W-1:0]   r_rem, w_rem_nx;
  logic [NIT-1:0]    r_root, w_root_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ROOT_W-1:0] r_out, w_out_fin;
  logic [REM_W-1:0]  r_rout, w_rout_fin;
  logic [RM_W+1:0]   w_rem_sh, w_trial;

  assign w_in_ext = RAD_W'(in) << (RAD_W - DATA_W);

  // Signed partial remainder: subtract the trial term when non-negative, add it back otherwise.
  assign w_rem_sh  = {r_rem, r_rad[RAD_W-1 -: 2]};
  assign w_trial   = {2'b00, r_root, r_rem[RM_W-1], 1'b1};
  assign w_rem_nx  = r_rem[RM_W-1] ? RM_W'(w_rem_sh + w_trial) : RM_W'(w_rem_sh - w_trial);
  assign w_root_nx = {r_root[NIT-2:0], ~w_rem_nx[RM_W-1]};

`ifdef SQRT_ITER_ROUND_EN
  logic [ROOT_W-1:0] w_floor;
  logic              w_guard;

  // Remainder is taken from the floor-root state, before the guard iteration.
  assign w_floor    = r_root[ROOT_W-1:0];
  assign w_guard    = ~w_rem_nx[RM_W-1];
  assign w_out_fin  = (w_guard && !(&w_floor)) ? w_floor + 1'b1 : w_floor;
  assign w_rout_fin = r_rem[RM_W-1] ? REM_W'(r_rem + {1'b0, r_root, 1'b1}) : REM_W'(r_rem);
`else
  assign w_out_fin  = w_root_nx;
  assign w_rout_fin = w_rem_nx[RM_W-1] ? REM_W'(w_rem_nx + {1'b0, w_root_nx, 1'b1})
                                       : REM_W'(w_rem_nx);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FIN accepts a new start like IDLE so back-to-back operations lose no cycle.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = S_CALC;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_last     = 1'b1;
          w_state_nx = S_FIN;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_rout <= '0;
    end else if (w_accept) begin
      r_rad  <= w_in_ext;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= CNT_W'(NIT - 1);
    end else if (r_state == S_CALC) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_rem_nx;
      r_root <= w_root_nx;
      if (w_last) begin
        r_out  <= w_out_fin;
        r_rout <= w_rout_fin;
      end else begin
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIN);
  assign out  = r_out;
  assign rout = r_rout;

endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - directed table-driven bench for sqrt_iter (default and EXT_FRAC=1 instances).
module tb_sqrt_iter;

`ifdef SQRT_ITER_ROUND_EN
  localparam int LAT0 = 18;
  localparam int LAT1 = 19;
  localparam bit RND  = 1'b1;
`else
  localparam int LAT0 = 17;
  localparam int LAT1 = 18;
  localparam bit RND  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0, s1;
  logic [31:0] i0, i1;
  logic        b0, b1, d0, d1;
  logic [15:0] o0;
  logic [16:0] r0;
  logic [16:0] o1;
  logic [17:0] r1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.DATA_W(32), .EXT_FRAC(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(s0), .in(i0),
    .busy(b0), .done(d0), .out(o0), .rout(r0)
  );

  sqrt_iter #(.DATA_W(32), .EXT_FRAC(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(s1), .in(i1),
    .busy(b1), .done(d1), .out(o1), .rout(r1)
  );

  typedef struct {
    logic [31:0] din;
    logic [15:0] q;
    logic [16:0] r;
    logic [15:0] q_rnd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input int which, input logic [31:0] d, input int lat, input string nm,
                        input logic [63:0] eq, input logic [63:0] er);
    int cyc;
    logic [63:0] held;
    @(negedge clk);
    if (which == 0) begin s0 = 1'b1; i0 = d; end
    else            begin s1 = 1'b1; i1 = d; end
    @(negedge clk);
    s0 = 1'b0; s1 = 1'b0;
    i0 = $urandom; i1 = $urandom;
    cyc = 1;
    while (!(which == 0 ? d0 : d1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(lat));
    check({nm, " out"},  (which == 0) ? 64'(o0) : 64'(o1), eq);
    check({nm, " rout"}, (which == 0) ? 64'(r0) : 64'(r1), er);
    check({nm, " busy at done"}, (which == 0) ? 64'(b0) : 64'(b1), 64'd0);
    held = (which == 0) ? 64'(o0) : 64'(o1);
    @(negedge clk);
    check({nm, " done pulse"}, (which == 0) ? 64'(d0) : 64'(d1), 64'd0);
    check({nm, " out held"}, (which == 0) ? 64'(o0) : 64'(o1), held);
  endtask

  initial begin
    int n_done, first, second, cyc;

    vecs[0]  = '{32'd140,        16'd11,     17'd19,      16'd12};
    vecs[1]  = '{32'd2048,       16'd45,     17'd23,      16'd45};
    vecs[2]  = '{32'd9216,       16'd96,     17'd0,       16'd96};
    vecs[3]  = '{32'd0,          16'd0,      17'd0,       16'd0};
    vecs[4]  = '{32'hFFFF_FFFF,  16'hFFFF,   17'h1FFFE,   16'hFFFF};
    vecs[5]  = '{32'd1,          16'd1,      17'd0,       16'd1};
    vecs[6]  = '{32'd2,          16'd1,      17'd1,       16'd1};
    vecs[7]  = '{32'd3,          16'd1,      17'd2,       16'd2};
    vecs[8]  = '{32'd99,         16'd9,      17'd18,      16'd10};
    vecs[9]  = '{32'hFFFE_0001,  16'hFFFF,   17'd0,       16'hFFFF};
    vecs[10] = '{32'h4000_0000,  16'h8000,   17'd0,       16'h8000};
    vecs[11] = '{32'd12,         16'd3,      17'd3,       16'd3};

    rstn = 1'b0; s0 = 1'b0; s1 = 1'b0; i0 = '0; i1 = '0;
    repeat (3) @(negedge clk);
    check("reset busy",  64'(b0), 64'd0);
    check("reset done",  64'(d0), 64'd0);
    check("reset out",   64'(o0), 64'd0);
    check("reset rout",  64'(r0), 64'd0);
    check("reset out1",  64'(o1), 64'd0);
    rstn = 1'b1;

    for (int k = 0; k < 12; k++) begin
      run_op(0, vecs[k].din, LAT0, $sformatf("vec%0d", k),
             RND ? 64'(vecs[k].q_rnd) : 64'(vecs[k].q), 64'(vecs[k].r));
    end

    // EXT_FRAC=1: 2048<<2 = 8192, sqrt = 90.5
    run_op(1, 32'd2048, LAT1, "extfrac", RND ? 64'd91 : 64'd90, 64'd92);

    // start held high: done every LAT0 cycles
    @(negedge clk);
    s0 = 1'b1; i0 = 32'd9216;
    n_done = 0; first = 0; second = 0;
    for (int c = 1; c <= 2 * LAT0; c++) begin
      @(negedge clk);
      if (d0) begin
        if (n_done == 0) first = c;
        else if (n_done == 1) second = c;
        n_done++;
      end
    end
    s0 = 1'b0;
    check("hold first done",  64'(first),  64'(LAT0));
    check("hold second done", 64'(second), 64'(2 * LAT0));
    check("hold done count",  64'(n_done), 64'd2);
    check("hold out",         64'(o0),     64'd96);
    @(negedge clk);
    check("hold idle after",  64'(b0),     64'd0);

    // start pulse while busy is ignored
    @(negedge clk);
    s0 = 1'b1; i0 = 32'd140;
    @(negedge clk);
    s0 = 1'b0; i0 = 32'd2048;
    cyc = 1;
    while (!d0 && cyc < 200) begin
      if (cyc == 5) begin
        check("ignore busy high", 64'(b0), 64'd1);
        s0 = 1'b1;
      end else begin
        s0 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    s0 = 1'b0;
    check("ignore latency", 64'(cyc), 64'(LAT0));
    check("ignore out",  64'(o0), RND ? 64'd12 : 64'd11);
    check("ignore rout", 64'(r0), 64'd19);
    @(negedge clk);
    check("ignore no second op", 64'(b0), 64'd0);

    // reset in cycle 5 of an operation
    @(negedge clk);
    s0 = 1'b1; i0 = 32'd2048;
    @(negedge clk);
    s0 = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset busy before", 64'(b0), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset busy", 64'(b0), 64'd0);
    check("midreset done", 64'(d0), 64'd0);
    check("midreset out",  64'(o0), 64'd0);
    check("midreset rout", 64'(r0), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (d0) n_done++;
    end
    check("midreset no done", 64'(n_done), 64'd0);
    check("midreset out stays", 64'(o0), 64'd0);
    run_op(0, 32'd140, LAT0, "after reset", RND ? 64'd12 : 64'd11, 64'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
